// File: rtl/fp_divider.sv
// Iterative signed fixed-point divider, one quotient bit per clock, start/done handshake.
// Define FP_DIV_ROUND_EN to add a guard bit and round half away from zero.
module fp_divider #(
  parameter int WORD_LENGTH = 8,
  parameter int A_QI        = 2,
  parameter int B_QI        = 2,
  parameter int O_QI        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] a_in,
  input  logic [WORD_LENGTH-1:0] b_in,
  output logic [WORD_LENGTH-1:0] d_out,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic                   overflow
);
  localparam int WL    = WORD_LENGTH;
  localparam int SHIFT = A_QI - B_QI + WORD_LENGTH - O_QI;
  localparam int ITER  = WORD_LENGTH + SHIFT;
`ifdef FP_DIV_ROUND_EN
  localparam int STEPS = ITER + 1;
`else
  localparam int STEPS = ITER;
`endif
  localparam int SHIFT_R = STEPS - WL;
  localparam int CW      = $clog2(STEPS + 1);

  localparam logic [STEPS-1:0] POS_LIM = STEPS'((1 << (WL - 1)) - 1);
  localparam logic [STEPS-1:0] NEG_LIM = STEPS'(1 << (WL - 1));
  localparam logic [WL-1:0]    MAX_POS = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0]    MIN_NEG = {1'b1, {(WL-1){1'b0}}};

  if (SHIFT < 0) begin : g_bad_shift
    $error("fp_divider: A_QI-B_QI+WORD_LENGTH-O_QI must be >= 0");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [STEPS-1:0] num_q, num_d;
  logic [STEPS-1:0] quo_q, quo_d;
  logic [WL-1:0]    rem_q, rem_d;
  logic [WL:0]      b_mag_q, b_mag_d;
  logic             sign_q, sign_d;
  logic             a_neg_q, a_neg_d;
  logic             dz_q, dz_d;
  logic [WL-1:0]    d_out_q, d_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WL-1:0]    a_mag;
  logic [WL:0]      b_mag_in;
  logic [WL:0]      trial;
  logic [WL:0]      diff;
  logic             ge;
  logic [STEPS-1:0] q_mag;

  // Magnitudes: 0x80.. maps to 2^(WL-1), which still fits as unsigned
  assign a_mag    = a_in[WL-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag_in = {1'b0, (b_in[WL-1] ? (~b_in + 1'b1) : b_in)};
  assign trial    = {rem_q, num_q[STEPS-1]};
  assign diff     = trial - b_mag_q;
  assign ge       = (trial >= b_mag_q);

`ifdef FP_DIV_ROUND_EN
  assign q_mag = STEPS'(({1'b0, quo_q} + (STEPS+1)'(1)) >> 1);
`else
  assign q_mag = quo_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (b_in == '0) ? FIN : CALC;
      CALC:    if (cnt_q == CW'(STEPS - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    num_d   = num_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    b_mag_d = b_mag_q;
    sign_d  = sign_q;
    a_neg_d = a_neg_q;
    dz_d    = dz_q;
    d_out_d = d_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d   = '0;
        num_d   = STEPS'(a_mag) << SHIFT_R;
        quo_d   = '0;
        rem_d   = '0;
        b_mag_d = b_mag_in;
        sign_d  = a_in[WL-1] ^ b_in[WL-1];
        a_neg_d = a_in[WL-1];
        dz_d    = (b_in == '0);
        busy_d  = 1'b1;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      CALC: begin
        num_d = num_q << 1;
        rem_d = ge ? diff[WL-1:0] : trial[WL-1:0];
        quo_d = {quo_q[STEPS-2:0], ge};
        cnt_d = cnt_q + CW'(1);
      end
      FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (dz_q) begin
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          d_out_d = a_neg_q ? MIN_NEG : MAX_POS;
        end else if (!sign_q && q_mag > POS_LIM) begin
          ovf_d   = 1'b1;
          d_out_d = MAX_POS;
        end else if (sign_q && q_mag > NEG_LIM) begin
          ovf_d   = 1'b1;
          d_out_d = MIN_NEG;
        end else begin
          d_out_d = sign_q ? (~q_mag[WL-1:0] + 1'b1) : q_mag[WL-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      d_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      b_mag_q <= b_mag_d;
      sign_q  <= sign_d;
      a_neg_q <= a_neg_d;
      dz_q    <= dz_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d_out       = d_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Iterative signed fixed-point divider; computes d_out = a_in / b_in, one quotient bit per clock.
- Inverse companion of the synthesizer's combinational fixed-point multiplier. Used for gain normalisation and envelope-rate computation, where a multi-cycle result is acceptable.
- Start/done handshake. Result is truncated toward zero and saturated to the output Q format.

Parameters:
- WORD_LENGTH, 8, total bits of a_in, b_in and d_out
- A_QI, 2, integer bits (incl. sign) of a_in; fractional bits = WORD_LENGTH-A_QI
- B_QI, 2, integer bits (incl. sign) of b_in
- O_QI, 2, integer bits (incl. sign) of d_out
- Derived SHIFT = A_QI-B_QI+WORD_LENGTH-O_QI; must be >= 0 (elaboration error otherwise)
- Derived ITER = WORD_LENGTH+SHIFT (default 14)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a_in  input  WORD_LENGTH  signed dividend, Q(A_QI).(WORD_LENGTH-A_QI)
- b_in  input  WORD_LENGTH  signed divisor, Q(B_QI).(WORD_LENGTH-B_QI)
- d_out  output  WORD_LENGTH  signed quotient, Q(O_QI).(WORD_LENGTH-O_QI); held until next done
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; d_out and flags valid from this cycle
- div_by_zero  output  1  b_in was 0 for this result
- overflow  output  1  result saturated

Behaviour:
- Reset (async, rst_n=0): state IDLE; d_out=0, busy=0, done=0, div_by_zero=0, overflow=0; counter and internal registers cleared. Reset mid-CALC aborts the operation with no done pulse.
- FSM states: IDLE, CALC, FIN.
  - IDLE: on start=1, latch sign=a[msb]^b[msb], |a|, |b|, and go to CALC (busy=1). Exception: if b_in==0, go directly to FIN.
  - CALC: restoring division of N=|a|<<SHIFT (width WORD_LENGTH+SHIFT+1) by |b|. Each cycle: shift the partial remainder left by one and bring in the next numerator MSB; if remainder>=|b|, subtract and set the quotient bit to 1. Runs exactly ITER cycles, counted by an internal counter, then goes to FIN.
  - FIN (one cycle): register d_out and flags; done=1, busy=0; next state IDLE.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - start in the FIN cycle is ignored.
  - start in the IDLE cycle immediately after FIN is accepted (back-to-back throughput = ITER+2 cycles).
  - Inputs are needed only in the accept cycle and may change afterwards.
- Latency: done asserts ITER+1 rising edges after the accepting edge; 1 edge for divide-by-zero.
- Saturation, applied to magnitude q:
  - positive result: q > 2^(WL-1)-1 -> d_out=0x7F..F, overflow=1
  - negative result: q > 2^(WL-1) -> d_out=0x80..0, overflow=1
  - otherwise d_out = sign ? -q : q
- Zero and sign edge cases:
  - A zero quotient is always +0; no negative-zero handling is required.
  - |min negative| inputs (e.g. 0x80) are handled with a WORD_LENGTH+1-bit magnitude.
- Divide by zero: div_by_zero=1, overflow=0; d_out = 0x7F..F if a_in>=0, else 0x80..0.
- Flags clear in the cycle a new start is accepted.

Optional Feature:
- Macro FP_DIV_ROUND_EN.
- Defined: CALC runs ITER+1 cycles to produce one guard bit. The magnitude is rounded half away from zero (q = (q_ext+1)>>1) before saturation. Latency becomes ITER+2.
- Undefined: truncation toward zero, latency ITER+1, no guard logic.

Test Plan (defaults, Q2.6, 1.0=0x40):
- a=0x20 (0.5), b=0x40 (1.0), start pulse -> done at edge 15 after accept, d_out=0x20, overflow=0, div_by_zero=0.
- a=0xD0 (-0.75), b=0x20 (0.5) -> d_out=0xA0 (-1.5), flags 0; b=0x20 by a=0x80 (-2.0 / 0.5 = -4) -> d_out=0x80, overflow=1.
- a=0x40, b=0x20 (2.0, not representable) -> d_out=0x7F, overflow=1.
- a=0x40, b=0x00 -> done 1 edge after accept, d_out=0x7F, div_by_zero=1; a=0xC0, b=0 -> d_out=0x80.
- a=0x20, b=0x30 (0.5/0.75): without macro d_out=0x2A; with FP_DIV_ROUND_EN d_out=0x2B, done at edge 16.
- Two further protocol checks:
  - start re-pulsed mid-CALC -> ignored; the result belongs to the first operands.
  - rst_n low at CALC cycle 5 -> all outputs 0 immediately; no done pulse; a new start after release completes normally.
